// File: rtl/enc_spi_responder.sv
// SPI slave model of the ENC28J60 control-register interface with a banked 4x32-byte register file.
// Optional macro ENC_RESP_MAC_DUMMY_EN: RCR of a MAC/MII register returns a dummy 0x00 byte first.
module enc_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             SS,
    output logic             MISO,
    output logic             wr_valid,
    output logic [1:0]       wr_bank,
    output logic [4:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             soft_rst,
    output logic [CNT_W-1:0] frame_cnt
);

`ifdef ENC_RESP_MAC_DUMMY_EN
    localparam bit DUMMY_EN = 1'b1;
`else
    localparam bit DUMMY_EN = 1'b0;
`endif

    localparam int unsigned RF_DEPTH  = 128;
    localparam logic [6:0]  ECON1_IDX = 7'h1F;
    localparam logic [2:0]  OP_RCR    = 3'b000;
    localparam logic [2:0]  OP_WCR    = 3'b010;
    localparam logic [2:0]  OP_BFS    = 3'b100;
    localparam logic [2:0]  OP_BFC    = 3'b101;
    localparam logic [2:0]  OP_SRC    = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DUMMY, S_DATA, S_HOLD} state_e;

    // Addresses 0x1B-0x1F share one physical copy, kept in bank 0.
    function automatic logic [6:0] rf_idx(input logic [1:0] b, input logic [4:0] a);
        return (a >= 5'h1B) ? {2'b00, a} : {b, a};
    endfunction

    function automatic logic is_mac(input logic [1:0] b, input logic [4:0] a);
        return ((b == 2'd2) && (a <= 5'h1A)) ||
               ((b == 2'd3) && ((a <= 5'h05) || (a == 5'h0A)));
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    state_e             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shift_q, shift_d;
    logic [2:0]         op_q, op_d;
    logic [4:0]         addr_q, addr_d;
    logic [1:0]         bank_q, bank_d;
    logic               src_q, src_d;
    logic [15:0]        tx_q, tx_d;
    logic               miso_q, miso_d;
    logic               wr_valid_q, wr_valid_d;
    logic [1:0]         wr_bank_q, wr_bank_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               soft_rst_q, soft_rst_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [7:0]         rf_q [RF_DEPTH];
    logic               rf_we, rf_clr;
    logic [6:0]         rf_widx;
    logic [7:0]         rf_wdata;

    logic [7:0]         rx_byte_c, rd_val_c, cur_val_c, commit_val_c;
    logic [2:0]         cmd_op_c;
    logic [4:0]         cmd_addr_c;
    logic               cmd_mac_c, tgt_mac_c, last_bit_c;

    // Pin synchronizers; SS resets low so a frame needs a fresh high-to-low after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    assign rx_byte_c  = {shift_q, mosi_s};
    assign cmd_op_c   = rx_byte_c[7:5];
    assign cmd_addr_c = rx_byte_c[4:0];
    assign cmd_mac_c  = is_mac(bank_q, cmd_addr_c);
    assign tgt_mac_c  = is_mac(bank_q, addr_q);
    assign rd_val_c   = rf_q[rf_idx(bank_q, cmd_addr_c)];
    assign cur_val_c  = rf_q[rf_idx(bank_q, addr_q)];
    assign last_bit_c = sclk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        case (op_q)
            OP_BFS:  commit_val_c = cur_val_c | rx_byte_c;
            OP_BFC:  commit_val_c = cur_val_c & ~rx_byte_c;
            default: commit_val_c = rx_byte_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ss_fall) state_d = S_CMD;
            S_CMD: begin
                if (ss_rise) begin
                    state_d = S_IDLE;
                end else if (last_bit_c) begin
                    case (cmd_op_c)
                        OP_RCR:                 state_d = (DUMMY_EN && cmd_mac_c) ? S_DUMMY : S_DATA;
                        OP_WCR, OP_BFS, OP_BFC: state_d = S_DATA;
                        default:                state_d = S_HOLD;
                    endcase
                end
            end
            S_DUMMY: if (ss_rise) state_d = S_IDLE; else if (last_bit_c) state_d = S_DATA;
            S_DATA:  if (ss_rise) state_d = S_IDLE; else if (last_bit_c) state_d = S_HOLD;
            S_HOLD:  if (ss_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        op_d        = op_q;
        addr_d      = addr_q;
        bank_d      = bank_q;
        src_d       = src_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        wr_valid_d  = 1'b0;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        soft_rst_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        rf_we       = 1'b0;
        rf_clr      = 1'b0;
        rf_widx     = rf_idx(bank_q, addr_q);
        rf_wdata    = commit_val_c;
        if (state_q != S_IDLE && ss_rise) begin
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            if (state_q == S_HOLD) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                if (src_q) begin
                    soft_rst_d = 1'b1;
                    rf_clr     = 1'b1;
                end
            end
        end else begin
            if (sclk_rise) begin
                shift_d   = rx_byte_c[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (ss_fall) begin
                        bit_cnt_d = '0;
                        bank_d    = rf_q[ECON1_IDX][1:0];
                        src_d     = 1'b0;
                    end
                end
                S_CMD: begin
                    if (sclk_fall) miso_d = 1'b0;
                    if (last_bit_c) begin
                        op_d   = cmd_op_c;
                        addr_d = cmd_addr_c;
                        src_d  = (cmd_op_c == OP_SRC);
                        tx_d   = (DUMMY_EN && cmd_mac_c) ? {8'h00, rd_val_c} : {rd_val_c, 8'h00};
                    end
                end
                S_DUMMY, S_DATA: begin
                    // Read data leaves MSB-first on falling edges; writes keep MISO low.
                    if (sclk_fall) begin
                        if (state_q == S_DUMMY || op_q == OP_RCR) begin
                            miso_d = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                    if (state_q == S_DATA && last_bit_c && op_q != OP_RCR &&
                        (op_q == OP_WCR || !tgt_mac_c)) begin
                        rf_we      = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_bank_d  = bank_q;
                        wr_addr_d  = addr_q;
                        wr_data_d  = commit_val_c;
                    end
                end
                default: miso_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            bank_q      <= '0;
            src_q       <= 1'b0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_bank_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            soft_rst_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            bank_q      <= bank_d;
            src_q       <= src_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            soft_rst_q  <= soft_rst_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= 8'h00;
        end else if (rf_clr) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= 8'h00;
        end else if (rf_we) begin
            rf_q[rf_widx] <= rf_wdata;
        end
    end

    assign MISO      = miso_q;
    assign wr_valid  = wr_valid_q;
    assign wr_bank   = wr_bank_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign soft_rst  = soft_rst_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_enc_spi_responder.sv
// Directed self-checking bench for enc_spi_responder (SPI mode 0 master model, commit monitor).
module tb_enc_spi_responder;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             SCLK;
    logic             MOSI;
    logic             SS;
    logic             MISO;
    logic             wr_valid;
    logic [1:0]       wr_bank;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             soft_rst;
    logic [CNT_W-1:0] frame_cnt;

    int          checks   = 0;
    int          errors   = 0;
    int          srst_cnt = 0;
    logic [14:0] wr_log[$];

    enc_spi_responder #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .soft_rst(soft_rst), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Records every commit pulse and soft-reset pulse seen on the outputs.
    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_bank, wr_addr, wr_data});
        if (soft_rst) srst_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            tick(HALF);
            rx[i] = MISO;
            SCLK = 1'b1;
            tick(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic ss_begin();
        SS = 1'b0;
        tick(4);
    endtask

    task automatic ss_end();
        tick(4);
        SS = 1'b1;
        tick(10);
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] d);
        logic [7:0] rx;
        ss_begin();
        xfer(cmd, 8, rx);
        xfer(d, 8, rx);
        ss_end();
    endtask

    task automatic rd_frame(input logic [7:0] cmd, input bit mac, output logic [7:0] dummy,
                            output logic [7:0] val);
        logic [7:0] rx;
        ss_begin();
        xfer(cmd, 8, rx);
        dummy = 8'h00;
`ifdef ENC_RESP_MAC_DUMMY_EN
        if (mac) xfer(8'h00, 8, dummy);
`else
        if (mac) dummy = 8'h00;
`endif
        xfer(8'h00, 8, val);
        ss_end();
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        checks++;
        if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++;
        if ({wr_bank, wr_addr, wr_data} !== 15'h0) begin
            errors++; $display("FAIL reset_wr_fields: got %h expected 0000", {wr_bank, wr_addr, wr_data});
        end
        checks++;
        if (soft_rst !== 1'b0) begin errors++; $display("FAIL reset_soft_rst: got %b expected 0", soft_rst); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        rst_n = 1'b1;
        tick(6);
    endtask

    task automatic test_wcr_bank();
        logic [14:0] got;
        wr_log.delete();
        wr_frame(8'h5F, 8'h02);
        wr_frame(8'h45, 8'hA5);
        checks++;
        if (wr_log.size() != 2) begin errors++; $display("FAIL wcr_count: got %0d expected 2", wr_log.size()); end
        got = (wr_log.size() > 0) ? wr_log[0] : 'x;
        checks++;
        if (got !== {2'd0, 5'h1F, 8'h02}) begin errors++; $display("FAIL wcr_first: got %h expected %h", got, {2'd0, 5'h1F, 8'h02}); end
        got = (wr_log.size() > 1) ? wr_log[1] : 'x;
        checks++;
        if (got !== {2'd2, 5'h05, 8'hA5}) begin errors++; $display("FAIL wcr_second: got %h expected %h", got, {2'd2, 5'h05, 8'hA5}); end
        checks++;
        if (frame_cnt !== 16'd2) begin errors++; $display("FAIL wcr_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_bfs_bfc();
        logic [14:0] got;
        logic [7:0]  dmy, val;
        wr_log.delete();
        wr_frame(8'h9B, 8'hF0);
        wr_frame(8'hBB, 8'h30);
        rd_frame(8'h1B, 1'b0, dmy, val);
        got = (wr_log.size() > 0) ? wr_log[0] : 'x;
        checks++;
        if (got !== {2'd2, 5'h1B, 8'hF0}) begin errors++; $display("FAIL bfs_commit: got %h expected %h", got, {2'd2, 5'h1B, 8'hF0}); end
        got = (wr_log.size() > 1) ? wr_log[1] : 'x;
        checks++;
        if (got !== {2'd2, 5'h1B, 8'hC0}) begin errors++; $display("FAIL bfc_commit: got %h expected %h", got, {2'd2, 5'h1B, 8'hC0}); end
        checks++;
        if (val !== 8'hC0) begin errors++; $display("FAIL rcr_common: got %h expected c0", val); end
        checks++;
        if (frame_cnt !== 16'd5) begin errors++; $display("FAIL bfs_frame_cnt: got %0d expected 5", frame_cnt); end
    endtask

    task automatic test_mac_read();
        logic [14:0] got;
        logic [7:0]  dmy, val;
        wr_log.delete();
        wr_frame(8'h40, 8'h3C);
        rd_frame(8'h00, 1'b1, dmy, val);
        got = (wr_log.size() > 0) ? wr_log[0] : 'x;
        checks++;
        if (got !== {2'd2, 5'h00, 8'h3C}) begin errors++; $display("FAIL mac_wcr: got %h expected %h", got, {2'd2, 5'h00, 8'h3C}); end
`ifdef ENC_RESP_MAC_DUMMY_EN
        checks++;
        if (dmy !== 8'h00) begin errors++; $display("FAIL mac_dummy: got %h expected 00", dmy); end
`endif
        checks++;
        if (val !== 8'h3C) begin errors++; $display("FAIL mac_rcr: got %h expected 3c", val); end
        // Bit-field set on a MAC register is dropped without a commit.
        wr_frame(8'h80, 8'h01);
        rd_frame(8'h00, 1'b1, dmy, val);
        checks++;
        if (wr_log.size() != 1) begin errors++; $display("FAIL mac_bfs_ignored: got %0d commits expected 1", wr_log.size()); end
        checks++;
        if (val !== 8'h3C) begin errors++; $display("FAIL mac_bfs_value: got %h expected 3c", val); end
        checks++;
        if (frame_cnt !== 16'd9) begin errors++; $display("FAIL mac_frame_cnt: got %0d expected 9", frame_cnt); end
    endtask

    task automatic test_partial_write();
        logic [7:0] rx, dmy, val;
        wr_log.delete();
        ss_begin();
        xfer(8'h44, 8, rx);
        xfer(8'hFF, 5, rx);
        ss_end();
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL partial_commit: got %0d commits expected 0", wr_log.size()); end
        checks++;
        if (frame_cnt !== 16'd9) begin errors++; $display("FAIL partial_frame_cnt: got %0d expected 9", frame_cnt); end
        rd_frame(8'h04, 1'b1, dmy, val);
        checks++;
        if (val !== 8'h00) begin errors++; $display("FAIL partial_readback: got %h expected 00", val); end
    endtask

    task automatic test_src();
        logic [7:0] rx, dmy, val;
        wr_log.delete();
        wr_frame(8'h5F, 8'h03);
        ss_begin();
        xfer(8'hFF, 8, rx);
        ss_end();
        checks++;
        if (srst_cnt != 1) begin errors++; $display("FAIL src_pulse: got %0d pulses expected 1", srst_cnt); end
        checks++;
        if (frame_cnt !== 16'd12) begin errors++; $display("FAIL src_frame_cnt: got %0d expected 12", frame_cnt); end
        rd_frame(8'h1F, 1'b0, dmy, val);
        checks++;
        if (val !== 8'h00) begin errors++; $display("FAIL src_econ1: got %h expected 00", val); end
        rd_frame(8'h1B, 1'b0, dmy, val);
        checks++;
        if (val !== 8'h00) begin errors++; $display("FAIL src_clear_1b: got %h expected 00", val); end
    endtask

    task automatic test_reset_mid_cmd();
        logic [7:0]  rx;
        logic [14:0] got;
        ss_begin();
        xfer(8'h5F, 4, rx);
        rst_n = 1'b0;
        #1;
        checks++;
        if (MISO !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b expected 0", MISO); end
        checks++;
        if ({wr_bank, wr_addr, wr_data} !== 15'h0) begin
            errors++; $display("FAIL rst_mid_wr_fields: got %h expected 0000", {wr_bank, wr_addr, wr_data});
        end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_frame_cnt: got %0d expected 0", frame_cnt); end
        tick(3);
        rst_n = 1'b1;
        wr_log.delete();
        xfer(8'hF0, 4, rx);
        xfer(8'h01, 8, rx);
        ss_end();
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL rst_mid_commit: got %0d commits expected 0", wr_log.size()); end
        checks++;
        if (rx !== 8'h00) begin errors++; $display("FAIL rst_mid_miso_data: got %h expected 00", rx); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_no_frame: got %0d expected 0", frame_cnt); end
        wr_frame(8'h5F, 8'h01);
        got = (wr_log.size() > 0) ? wr_log[0] : 'x;
        checks++;
        if (got !== {2'd0, 5'h1F, 8'h01}) begin errors++; $display("FAIL rst_mid_next_frame: got %h expected %h", got, {2'd0, 5'h1F, 8'h01}); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_next_cnt: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        SS    = 1'b1;
        test_reset();
        test_wcr_bank();
        test_bfs_bfc();
        test_mac_read();
        test_partial_write();
        test_src();
        test_reset_mid_cmd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
